hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Produces the stall and flush inputs consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus PC write-enable.
- Combines start sequencing, load-use bubble insertion, taken-branch flush, and a multi-cycle data-memory hold FSM.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
MEM_LAT, 4, data-memory access hold length in cycles; legal range 1..255.
CNT_W, 32, width of stall_cnt_o.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  leaves IDLE when sampled high; ignored afterwards
id_rs1_i  input  5  rs1 of the instruction in ID
id_rs2_i  input  5  rs2 of the instruction in ID
ex_memread_i  input  1  instruction in EX is a load
ex_rd_i  input  5  destination register of the instruction in EX
id_branch_taken_i  input  1  branch resolved taken in ID
mem_req_i  input  1  instruction in MEM accesses data memory
pc_write_o  output  1  PC update enable
ifid_stall_o  output  1  IF/ID hold
ifid_flush_o  output  1  IF/ID clear
idex_flush_o  output  1  ID/EX bubble insertion
pipe_hold_o  output  1  hold ID/EX, EX/MEM, MEM/WB
stall_cnt_o  output  CNT_W  count of stalled cycles

Behaviour:
- States: IDLE, RUN, MEMWAIT, MEMDONE. An 8-bit down-counter cnt supports MEMWAIT.
- Reset (async, any time, including mid-MEMWAIT): state=IDLE, cnt=0, stall_cnt_o=0.
- IDLE outputs: pc_write_o=0, ifid_stall_o=1, pipe_hold_o=1, ifid_flush_o=0, idex_flush_o=0.
- IDLE -> RUN on the first edge with start_i=1. No other path returns to IDLE except reset.
- Memory hold FSM:
  - RUN with mem_req_i=1: hold cycle 1. Next state is MEMWAIT with cnt=MEM_LAT-2 if MEM_LAT>=2, else MEMDONE.
  - MEMWAIT: hold. If cnt==0, go to MEMDONE; else cnt decrements.
  - Result: hold is asserted for exactly MEM_LAT consecutive cycles.
  - MEMDONE: no hold; mem_req_i ignored (same instruction still in MEM). Always returns to RUN next edge.
- Hold outputs (combinational from state and inputs): pipe_hold_o=1, ifid_stall_o=1, pc_write_o=0, ifid_flush_o=0, idex_flush_o=0. Hold overrides load-use and branch.
- Load-use (RUN without hold, or MEMDONE):
  - Condition: ex_memread_i=1, ex_rd_i!=0, and ex_rd_i equals id_rs1_i or id_rs2_i.
  - Outputs: pc_write_o=0, ifid_stall_o=1, idex_flush_o=1, ifid_flush_o=0.
  - The branch is suppressed because its operands are not yet valid. It is re-evaluated next cycle.
- Taken branch (no hold, no load-use): ifid_flush_o=1, pc_write_o=1, ifid_stall_o=0.
- Default in RUN/MEMDONE: pc_write_o=1, all stalls and flushes 0.
- All outputs except stall_cnt_o are combinational. No latency is added to hazard response.
- stall_cnt_o:
  - Increments at each edge where state!=IDLE and pc_write_o==0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Registered, so it lags the stall cycle by one edge.
- ex_rd_i==0 never triggers load-use (x0).
- start_i pulses while in RUN/MEMWAIT/MEMDONE have no effect.

Test Plan:
- Reset then start_i=1 for one cycle:
  - Before the edge: pc_write_o=0, pipe_hold_o=1.
  - After the edge: pc_write_o=1, all stall/flush outputs 0, stall_cnt_o=0.
- RUN, ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 for one cycle:
  - Same cycle: pc_write_o=0, ifid_stall_o=1, idex_flush_o=1.
  - Next edge: stall_cnt_o=1.
  - Repeat with ex_rd_i=0: no stall.
- RUN, id_branch_taken_i=1:
  - ifid_flush_o=1, pc_write_o=1.
  - With a simultaneous load-use hit: ifid_flush_o=0, idex_flush_o=1.
- MEM_LAT=4, mem_req_i held high:
  - pipe_hold_o=1 for exactly 4 cycles.
  - MEMDONE cycle: pipe_hold_o=0 despite mem_req_i=1.
  - Next cycle in RUN with mem_req_i=1: new 4-cycle hold.
  - Repeat with MEM_LAT=1: 1-cycle hold.
- During hold, assert the load-use condition plus a taken branch:
  - Only hold outputs are active: idex_flush_o=0, ifid_flush_o=0.
- Assert rst_i asynchronously during MEMWAIT, mid-clock:
  - Outputs switch immediately to IDLE values; stall_cnt_o=0.
  - After rst_i drops, stay in IDLE until start_i.
- Preload scenario with CNT_W=4: after 15 stall cycles, stall_cnt_o remains 15 on further stalls.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: start sequencing, load-use bubbles, taken-branch
// flush, multi-cycle data-memory hold, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int MEM_LAT = 4,
   parameter int CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             id_branch_taken_i,
   input  logic             mem_req_i,
   output logic             pc_write_o,
   output logic             ifid_stall_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             pipe_hold_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {IDLE, RUN, MEMWAIT, MEMDONE} state_t;

   // The RUN cycle that sees mem_req_i is the first hold cycle, so MEMWAIT covers MEM_LAT-1.
   localparam logic [7:0] LAT_RELOAD = (MEM_LAT >= 2) ? 8'(MEM_LAT - 2) : 8'd0;

   state_t           r_state;
   logic [7:0]       r_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_hold;
   logic             w_load_use;

   assign w_hold     = (r_state == MEMWAIT) || ((r_state == RUN) && mem_req_i);
   assign w_load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                       ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

   always_comb begin
      pc_write_o   = 1'b1;
      ifid_stall_o = 1'b0;
      ifid_flush_o = 1'b0;
      idex_flush_o = 1'b0;
      pipe_hold_o  = 1'b0;
      if (r_state == IDLE) begin
         pc_write_o   = 1'b0;
         ifid_stall_o = 1'b1;
         pipe_hold_o  = 1'b1;
      end else if (w_hold) begin
         pc_write_o   = 1'b0;
         ifid_stall_o = 1'b1;
         pipe_hold_o  = 1'b1;
      end else if (w_load_use) begin
         // Branch operands depend on the load, so the branch waits for the retry.
         pc_write_o   = 1'b0;
         ifid_stall_o = 1'b1;
         idex_flush_o = 1'b1;
      end else if (id_branch_taken_i) begin
         ifid_flush_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
      end else begin
         case (r_state)
            IDLE: if (start_i) r_state <= RUN;
            RUN: if (mem_req_i) begin
               if (MEM_LAT >= 2) begin
                  r_state <= MEMWAIT;
                  r_cnt   <= LAT_RELOAD;
               end else begin
                  r_state <= MEMDONE;
               end
            end
            MEMWAIT: if (r_cnt == 8'd0) r_state <= MEMDONE;
                     else r_cnt <= r_cnt - 8'd1;
            MEMDONE: r_state <= RUN;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_stall_cnt <= '0;
      else if ((r_state != IDLE) && !pc_write_o && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances (MEM_LAT=4, MEM_LAT=1, CNT_W=4)
// driven in parallel; each phase scores one of them against queued expectations.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start, mr, br, mq;
   logic [4:0] rs1, rs2, rd;

   logic pcw0, ifs0, iff0, idf0, hld0; logic [31:0] cnt0;
   logic pcw1, ifs1, iff1, idf1, hld1; logic [31:0] cnt1;
   logic pcw2, ifs2, iff2, idf2, hld2; logic [3:0]  cnt2;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MEM_LAT(4), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .id_rs1_i(rs1), .id_rs2_i(rs2),
      .ex_memread_i(mr), .ex_rd_i(rd), .id_branch_taken_i(br), .mem_req_i(mq),
      .pc_write_o(pcw0), .ifid_stall_o(ifs0), .ifid_flush_o(iff0), .idex_flush_o(idf0),
      .pipe_hold_o(hld0), .stall_cnt_o(cnt0));

   hazard_stall_ctrl #(.MEM_LAT(1), .CNT_W(32)) dut_lat1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .id_rs1_i(rs1), .id_rs2_i(rs2),
      .ex_memread_i(mr), .ex_rd_i(rd), .id_branch_taken_i(br), .mem_req_i(mq),
      .pc_write_o(pcw1), .ifid_stall_o(ifs1), .ifid_flush_o(iff1), .idex_flush_o(idf1),
      .pipe_hold_o(hld1), .stall_cnt_o(cnt1));

   hazard_stall_ctrl #(.MEM_LAT(4), .CNT_W(4)) dut_sat (
      .clk_i(clk), .rst_i(rst), .start_i(start), .id_rs1_i(rs1), .id_rs2_i(rs2),
      .ex_memread_i(mr), .ex_rd_i(rd), .id_branch_taken_i(br), .mem_req_i(mq),
      .pc_write_o(pcw2), .ifid_stall_o(ifs2), .ifid_flush_o(iff2), .idex_flush_o(idf2),
      .pipe_hold_o(hld2), .stall_cnt_o(cnt2));

   // {pc_write, ifid_stall, ifid_flush, idex_flush, pipe_hold, stall_cnt}
   typedef logic [36:0] obs_t;
   obs_t q[$];

   int          total = 0;
   int          bad   = 0;
   int          sel   = 0;
   logic        running = 1'b0;
   logic [31:0] exp_cnt = 32'd0;

   function automatic obs_t observe();
      case (sel)
         1:       return {pcw1, ifs1, iff1, idf1, hld1, cnt1};
         2:       return {pcw2, ifs2, iff2, idf2, hld2, 28'd0, cnt2};
         default: return {pcw0, ifs0, iff0, idf0, hld0, cnt0};
      endcase
   endfunction

   task automatic check(input string tag);
      obs_t o, e;
      e = q.pop_front();
      o = observe();
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic drive(input logic s, input logic [4:0] a, input logic [4:0] b,
                        input logic m, input logic [4:0] d, input logic t, input logic r);
      start = s; rs1 = a; rs2 = b; mr = m; rd = d; br = t; mq = r;
   endtask

   // One cycle: drive at negedge, score combinational outputs before the rising edge,
   // then advance the bench's own stall-count expectation for that edge.
   task automatic step(input string tag, input logic s, input logic [4:0] a, input logic [4:0] b,
                       input logic m, input logic [4:0] d, input logic t, input logic r,
                       input logic [4:0] e);
      logic [31:0] cmax;
      @(negedge clk);
      drive(s, a, b, m, d, t, r);
      q.push_back({e, exp_cnt});
      #1 check(tag);
      cmax = (sel == 2) ? 32'd15 : 32'hFFFF_FFFF;
      if (running && !e[4] && exp_cnt != cmax) exp_cnt = exp_cnt + 1;
      if (!running && s) running = 1'b1;
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      running = 1'b0;
      exp_cnt = 32'd0;
   endtask

   // Expected output patterns {pcw, ifs, iff, idf, hold}
   localparam logic [4:0] E_IDLE = 5'b01001;
   localparam logic [4:0] E_HOLD = 5'b01001;
   localparam logic [4:0] E_RUN  = 5'b10000;
   localparam logic [4:0] E_LU   = 5'b01010;
   localparam logic [4:0] E_BR   = 5'b10100;

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      do_reset();

      // ---- MEM_LAT=4 instance ----
      sel = 0;
      step("idle_wait",   0, 0, 0, 0, 0, 0, 0, E_IDLE);
      step("start_pre",   1, 0, 0, 0, 0, 0, 0, E_IDLE);
      step("run_default", 0, 1, 2, 0, 0, 0, 0, E_RUN);
      step("loaduse_rs2", 0, 3, 5, 1, 5, 0, 0, E_LU);
      step("cnt_after_lu",0, 3, 4, 0, 0, 0, 0, E_RUN);
      step("rd_x0",       0, 0, 0, 1, 0, 0, 0, E_RUN);
      step("rd_nomatch",  0, 1, 2, 1, 9, 0, 0, E_RUN);
      step("branch",      0, 1, 2, 0, 0, 1, 0, E_BR);
      step("lu_over_br",  0, 7, 2, 1, 7, 1, 0, E_LU);
      step("start_in_run",1, 1, 2, 0, 0, 0, 0, E_RUN);
      step("hold1",       0, 0, 0, 0, 0, 0, 1, E_HOLD);
      step("hold2",       0, 0, 0, 0, 0, 0, 1, E_HOLD);
      step("hold3_lu_br", 0, 6, 0, 1, 6, 1, 1, E_HOLD);
      step("hold4",       0, 0, 0, 0, 0, 0, 1, E_HOLD);
      step("memdone",     0, 0, 0, 0, 0, 0, 1, E_RUN);
      step("rehold1",     0, 0, 0, 0, 0, 0, 1, E_HOLD);
      step("rehold2",     0, 0, 0, 0, 0, 0, 0, E_HOLD);
      step("rehold3",     0, 0, 0, 0, 0, 0, 0, E_HOLD);
      step("rehold4",     0, 0, 0, 0, 0, 0, 0, E_HOLD);
      step("memdone_lu",  0, 8, 0, 1, 8, 1, 0, E_LU);
      step("run_after",   0, 0, 0, 0, 0, 0, 0, E_RUN);
      step("hold_a",      0, 0, 0, 0, 0, 0, 1, E_HOLD);
      step("hold_b",      0, 0, 0, 0, 0, 0, 1, E_HOLD);

      // Asynchronous reset in the middle of MEMWAIT
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 1);
      #2 rst = 1'b1;
      running = 1'b0;
      exp_cnt = 32'd0;
      q.push_back({E_IDLE, 32'd0});
      #1 check("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step("post_rst_idle1", 0, 0, 0, 0, 0, 0, 0, E_IDLE);
      step("post_rst_idle2", 0, 0, 0, 0, 0, 0, 1, E_IDLE);
      step("restart",        1, 0, 0, 0, 0, 0, 0, E_IDLE);
      step("rerun",          0, 0, 0, 0, 0, 0, 0, E_RUN);

      // ---- MEM_LAT=1 instance ----
      do_reset();
      sel = 1;
      step("l1_start",   1, 0, 0, 0, 0, 0, 0, E_IDLE);
      step("l1_hold",    0, 0, 0, 0, 0, 0, 1, E_HOLD);
      step("l1_memdone", 0, 0, 0, 0, 0, 0, 1, E_RUN);
      step("l1_rehold",  0, 0, 0, 0, 0, 0, 1, E_HOLD);
      step("l1_done2",   0, 0, 0, 0, 0, 0, 0, E_RUN);
      step("l1_run",     0, 0, 0, 0, 0, 1, 0, E_BR);

      // ---- CNT_W=4 saturation ----
      do_reset();
      sel = 2;
      step("s_start", 1, 0, 0, 0, 0, 0, 0, E_IDLE);
      for (int i = 0; i < 18; i++)
         step("s_lu", 0, 3, 0, 1, 3, 0, 0, E_LU);
      step("s_sat", 0, 0, 0, 0, 0, 0, 0, E_RUN);
      step("s_sat2", 0, 0, 0, 0, 0, 0, 0, E_RUN);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
